// File: rtl/fetch_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_unit
// Purpose  : Instruction-fetch front end plus the IF/ID pipeline register.
//            Owns the program counter, applies branch/jump redirects, holds
//            on hazard stalls, inserts bubbles while a variable-latency
//            instruction memory has not answered, and counts the number of
//            real instructions handed to decode.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PC_W      program counter / address width in bits (>= 3)
//   RESET_PC  PC value loaded on reset
//   NOP_WORD  instruction word placed in IF/ID on a bubble or flush
// Ports
//   clk             rising-edge system clock
//   rst_n           asynchronous active-low reset
//   stall           hazard hold: freeze PC and IF/ID
//   branchTaken     branch resolved taken in EX (highest priority redirect)
//   branchTarget    branch destination byte address
//   jump            unconditional jump request
//   jumpTarget      jump destination byte address
//   imemAddr        instruction memory address (the PC register)
//   imemData        instruction word, meaningful when imemValid=1
//   imemValid       memory returns a valid word for imemAddr this cycle
//   outInstruction  IF/ID instruction
//   outPostPc       IF/ID PC+4 of outInstruction
//   outValid        IF/ID holds a real instruction (0 = bubble)
//   fetchCount      instructions delivered into IF/ID, wrapping counter
// ============================================================================
module fetch_stage_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_WORD = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branchTaken,
  input  logic [PC_W-1:0] branchTarget,
  input  logic            jump,
  input  logic [PC_W-1:0] jumpTarget,
  output logic [PC_W-1:0] imemAddr,
  input  logic [31:0]     imemData,
  input  logic            imemValid,
  output logic [31:0]     outInstruction,
  output logic [PC_W-1:0] outPostPc,
  output logic            outValid,
  output logic [31:0]     fetchCount
);

  // Sequential-fetch increment; the add is PC_W bits wide so it wraps
  // naturally at the top of the address space.
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  // IDLE : the single settling cycle after reset release
  // RUN  : normal fetch
  // MISS : the previous request was not answered; re-presenting the same PC
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MISS = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] post_pc_q, post_pc_d;
  logic            valid_q, valid_d;
  logic [31:0]     count_q, count_d;

  logic            redirect;
  logic [PC_W-1:0] redirect_target;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] pc_plus4;
  logic            unused_target_lsbs;

  // A branch outranks a jump, so the jump target is only selected when no
  // branch is being taken in the same cycle.
  assign redirect        = branchTaken | jump;
  assign redirect_target = branchTaken ? branchTarget : jumpTarget;

  // Instructions are word aligned; the low two target bits are discarded
  // rather than trusted.
  assign redirect_pc        = {redirect_target[PC_W-1:2], 2'b00};
  assign unused_target_lsbs = ^redirect_target[1:0];

  assign pc_plus4 = pc_q + PC_STEP;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Default: everything holds (this is also the stall behaviour).
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    post_pc_d = post_pc_q;
    valid_d   = valid_q;
    count_d   = count_q;

    case (state_q)
      ST_IDLE: begin
        // Settling cycle: nothing is captured and the PC stays put, even if
        // the memory or the hazard logic is already asserting something.
        state_d = ST_RUN;
      end

      default: begin
        if (redirect) begin
          // Flush: whatever the memory returns this cycle belongs to the
          // wrong path and is dropped, pending miss included.
          pc_d      = redirect_pc;
          instr_d   = NOP_WORD;
          post_pc_d = '0;
          valid_d   = 1'b0;
          state_d   = ST_RUN;
        end else if (stall) begin
          // Full hold. A word returned now is not captured; the same PC is
          // simply requested again once the stall clears.
          state_d = state_q;
        end else if (imemValid) begin
          instr_d   = imemData;
          post_pc_d = pc_plus4;
          valid_d   = 1'b1;
          pc_d      = pc_plus4;
          count_d   = count_q + 32'd1;
          state_d   = ST_RUN;
        end else begin
          // Memory not ready: push a bubble downstream and keep the PC.
          // outPostPc deliberately keeps its last value.
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          state_d = ST_MISS;
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_WORD;
      post_pc_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      post_pc_q <= post_pc_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all straight from registers, so there is no combinational path
  // from imemData or the redirect/stall inputs to any output.
  // --------------------------------------------------------------------------
  assign imemAddr       = pc_q;
  assign outInstruction = instr_q;
  assign outPostPc      = post_pc_q;
  assign outValid       = valid_q;
  assign fetchCount     = count_q;

endmodule
`default_nettype wire

// File: doc/fetch_stage_unit.md
Name: fetch_stage_unit

Overview:
Instruction-fetch front end with the IF/ID pipeline register. It sits directly upstream of the decode stage and drives the instruction, PC+4 and valid bit that StageID and ControlUnit consume. It owns the program counter, handles branch/jump redirects, stalls and flushes, and waits on a variable-latency instruction memory. It also keeps a delivered-instruction counter for debug.

Parameters:
PC_W, 32, program counter / address width in bits.
RESET_PC, 0, PC value loaded on reset.
NOP_WORD, 32'h00000000, instruction word injected on a bubble or flush.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hazard hold: freeze the PC and the IF/ID register.
branchTaken  in  1  branch resolved taken in EX.
branchTarget  in  PC_W  branch destination byte address.
jump  in  1  unconditional jump request.
jumpTarget  in  PC_W  jump destination byte address.
imemAddr  out  PC_W  instruction memory address; equals the PC register.
imemData  in  32  instruction word; meaningful only when imemValid=1.
imemValid  in  1  memory returns a valid word for imemAddr this cycle.
outInstruction  out  32  IF/ID instruction.
outPostPc  out  PC_W  IF/ID PC+4 of outInstruction.
outValid  out  1  IF/ID holds a real instruction; 0 means bubble.
fetchCount  out  32  number of instructions delivered into IF/ID; wraps.

Behaviour:
- Reset (asynchronous, at any time, including mid-miss):
  - pc=RESET_PC, state=IDLE, outInstruction=NOP_WORD, outPostPc=0, outValid=0, fetchCount=0.
- States: IDLE, RUN, MISS.
  - IDLE: exactly one cycle after reset release, then RUN. No capture; PC unchanged.
  - RUN: normal fetch.
  - MISS: waiting for imemValid at the held PC.
- PC width and alignment:
  - PC+4 is a PC_W-bit modular add; it wraps at all-ones.
  - Target bits [1:0] are forced to 00 when loaded into the PC.
- Event priority each edge: reset > branchTaken > jump > stall > memory.
- branchTaken=1 (any non-IDLE state):
  - pc<=branchTarget.
  - IF/ID<={NOP_WORD, 0, valid=0}.
  - state<=RUN.
  - Overrides stall and any pending miss; the missed word is discarded even if imemValid=1.
- jump=1 with branchTaken=0: same as a branch, using jumpTarget.
- stall=1, no redirect:
  - pc, IF/ID, state and fetchCount are all held.
  - A word returned during stall is not captured; the same PC is refetched after stall drops.
- RUN, imemValid=1:
  - IF/ID<={imemData, pc+4, 1}.
  - pc<=pc+4.
  - fetchCount<=fetchCount+1.
- RUN, imemValid=0:
  - IF/ID<={NOP_WORD, outPostPc unchanged, valid=0}.
  - pc held; state<=MISS.
- MISS, imemValid=0: bubble is inserted again (valid=0); pc held.
- MISS, imemValid=1: capture exactly as in RUN; state<=RUN.
- Latency: a word presented with imemValid=1 at edge N appears on the outputs after edge N. There is no combinational path from imemData to the outputs.
- imemAddr is combinational from the pc register only. It never depends on the same-cycle branchTaken, jump or stall.
- fetchCount:
  - Increments only on capture with outValid<=1.
  - Wraps from 32'hFFFFFFFF to 0.
  - Is not cleared by a flush.
- Simultaneous branchTaken=1 and jump=1: the branch wins, and jumpTarget is ignored.

Test Plan:
- Reset release, imemValid=1 constant, imem returns addr^32'hA5A5A5A5 -> after the IDLE cycle, imemAddr steps 0,4,8,12; outInstruction follows one cycle later; outPostPc=4,8,12; fetchCount=3 after three captures.
- Hold imemValid=0 for 3 cycles at pc=8 -> 3 consecutive bubbles (outValid=0, outInstruction=0); imemAddr stays 8; on imemValid=1, outPostPc=12 and state returns to RUN.
- branchTaken=1 with branchTarget=32'h43, asserted together with stall=1 and jump=1 (jumpTarget=32'h80) -> next imemAddr=32'h40, outValid=0; the jump and stall are ignored that cycle.
- stall=1 for 2 cycles while imemValid=1 at pc=16 -> imemAddr=16, IF/ID and fetchCount unchanged; the word at 16 is captured on the first edge after stall drops.
- Assert rst_n=0 asynchronously mid-MISS at pc=24 -> outputs clear immediately without a clock edge; imemAddr=RESET_PC; one IDLE cycle follows release.
- Preload pc=32'hFFFFFFFC via a jump, imemValid=1 -> capture gives outPostPc=0 and the next imemAddr=0 (wrap).
